// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated NS/EW intersection sequencer with a pedestrian all-walk phase.
// Latches vehicle and button demand, then applies min/max green, yellow and all-red timing.
`timescale 1ns/1ps
module traffic_phase_scheduler #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 5,
    parameter int CW        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_ns,
    input  logic       req_ew,
    input  logic       ped_req,
    output logic       ns_g,
    output logic       ns_y,
    output logic       ns_r,
    output logic       ew_g,
    output logic       ew_y,
    output logic       ew_r,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_NSG  = 3'd0,
        S_NSY  = 3'd1,
        S_AR1  = 3'd2,
        S_EWG  = 3'd3,
        S_EWY  = 3'd4,
        S_AR2  = 3'd5,
        S_WALK = 3'd6
    } state_t;

    typedef enum logic {DIR_NS = 1'b0, DIR_EW = 1'b1} dir_t;

    // A state of duration T exits on the cycle its timer reads T-1.
    localparam logic [CW-1:0] GMIN_LAST   = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX_LAST   = CW'(GREEN_MAX - 1);
    localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] WALK_LAST   = CW'(WALK_T - 1);

    state_t        state, nxt;
    dir_t          last_dir;
    logic [CW-1:0] tmr;
    logic          pend_ns, pend_ew, ped_pend;
    logic          ns_other, ew_other;

    // Lamp vector order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}.
    function automatic logic [6:0] lamps(input state_t s);
        case (s)
            S_NSG:   lamps = 7'b100_001_0;
            S_NSY:   lamps = 7'b010_001_0;
            S_EWG:   lamps = 7'b001_100_0;
            S_EWY:   lamps = 7'b001_010_0;
            S_WALK:  lamps = 7'b001_001_1;
            default: lamps = 7'b001_001_0;
        endcase
    endfunction

    assign ew_other = pend_ew | req_ew | ped_pend;
    assign ns_other = pend_ns | req_ns | ped_pend;

    always_comb begin
        nxt = state;
        case (state)
            S_NSG: if (ew_other && (tmr >= GMAX_LAST || (!req_ns && tmr >= GMIN_LAST))) nxt = S_NSY;
            S_NSY: if (tmr >= YELLOW_LAST) nxt = S_AR1;
            S_AR1: if (tmr >= ALLRED_LAST) nxt = ped_pend ? S_WALK : S_EWG;
            S_EWG: if (ns_other && (tmr >= GMAX_LAST || (!req_ew && tmr >= GMIN_LAST))) nxt = S_EWY;
            S_EWY: if (tmr >= YELLOW_LAST) nxt = S_AR2;
            S_AR2: if (tmr >= ALLRED_LAST) nxt = ped_pend ? S_WALK : S_NSG;
            S_WALK: if (tmr >= WALK_LAST) nxt = (last_dir == DIR_NS) ? S_EWG : S_NSG;
            default: nxt = S_NSG;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_NSG;
            tmr      <= '0;
            pend_ns  <= 1'b0;
            pend_ew  <= 1'b0;
            ped_pend <= 1'b0;
            last_dir <= DIR_NS;
            phase    <= 3'd0;
            {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk} <= 7'b100_001_0;
        end else begin
            state <= nxt;
            phase <= nxt;
            // NOTE: lamps decode the next state so they are registered yet never lag the state register.
            {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk} <= lamps(nxt);

            if (nxt != state)   tmr <= '0;
            else if (tmr != '1) tmr <= tmr + 1'b1;

            // Serving a direction's green discards its demand even if it is still asserted.
            if (nxt == S_NSG && state != S_NSG)  pend_ns <= 1'b0;
            else if (req_ns && state != S_NSG)   pend_ns <= 1'b1;

            if (nxt == S_EWG && state != S_EWG)  pend_ew <= 1'b0;
            else if (req_ew && state != S_EWG)   pend_ew <= 1'b1;

            if (nxt == S_WALK && state != S_WALK) ped_pend <= 1'b0;
            else if (ped_req && state != S_WALK)  ped_pend <= 1'b1;

            if (state == S_NSG && nxt != S_NSG)      last_dir <= DIR_NS;
            else if (state == S_EWG && nxt != S_EWG) last_dir <= DIR_EW;
        end
    end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Demand-actuated controller for a two-way (NS/EW) intersection with full red/yellow/green heads and a pedestrian all-walk phase. Latches vehicle-sensor and push-button requests. Applies min-green, max-green, yellow and all-red clearance timing. Arbitrates right-of-way between the two directions and the pedestrian phase. Replaces the fixed-period NS/EW toggler as the top-level signal sequencer.

Parameters:
GREEN_MIN, 4, minimum green cycles before any phase change
GREEN_MAX, 10, maximum green cycles when the other direction has demand
YELLOW_T, 3, yellow duration in cycles
ALLRED_T, 2, all-red clearance duration in cycles
WALK_T, 5, pedestrian walk duration (all vehicle heads red)
CW, 4, timer width; must hold max(all durations)-1

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
req_ns  input  1  NS vehicle sensor, level
req_ew  input  1  EW vehicle sensor, level
ped_req  input  1  pedestrian button, any pulse width ≥1 cycle
ns_g, ns_y, ns_r  output  1 each  NS signal head
ew_g, ew_y, ew_r  output  1 each  EW signal head
walk  output  1  pedestrian walk lamp
phase  output  3  current state code (debug)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- States and phase codes: NSG=0, NSY=1, AR1=2, EWG=3, EWY=4, AR2=5, WALK=6. Code 7 is illegal and goes to NSG on the next edge.
- Outputs are a Moore decode of the state register:
  - NSG: ns_g=1, ew_r=1.
  - NSY: ns_y=1, ew_r=1.
  - EWG: ew_g=1, ns_r=1.
  - EWY: ew_y=1, ns_r=1.
  - AR1, AR2, WALK: ns_r=1, ew_r=1.
  - walk=1 only in WALK.
  - Exactly one lamp per head is lit at all times. Green is never lit on both heads.
- Reset (async, immediate, including mid-phase):
  - state=NSG, tmr=0, pend_ns=pend_ew=ped_pend=0, last_dir=NS.
  - Outputs: ns_g=1, ew_r=1, all others 0, phase=0.
- Timer tmr:
  - Cleared on every state change; otherwise +1 per cycle.
  - Saturates at all-ones and never wraps.
  - A timed state of duration T therefore lasts exactly T cycles.
- Demand latches:
  - pend_ew is set when req_ew=1 and state≠EWG, and cleared on entry to EWG. pend_ns is the mirror for NS/NSG.
  - ped_pend is set on ped_req=1 in any state except WALK and the cycle entering WALK, and cleared on entry to WALK.
- Green exit (NSG; EWG is the mirror):
  - other = pend_ew | req_ew | ped_pend.
  - Exit to NSY when other=1 and either:
    - tmr ≥ GREEN_MAX-1 (max-out), or
    - req_ns=0 and tmr ≥ GREEN_MIN-1 (gap-out).
  - With other=0, remain green indefinitely (rest in green).
- Yellow: NSY→AR1 and EWY→AR2 after YELLOW_T cycles.
- All-red exit, after ALLRED_T cycles:
  - If ped_pend=1, go to WALK.
  - Otherwise AR1→EWG and AR2→NSG.
  - On leaving a green, last_dir records the direction that was green.
- WALK: after WALK_T cycles, go to the green opposite last_dir (NS→EWG, EW→NSG).
- Simultaneous events:
  - Requests arriving in the exit cycle of a green are latched normally.
  - ped_req during WALK is ignored.

Test Plan:
- Reset: assert reset mid-EWY asynchronously → same-cycle ns_g=1, ew_r=1, walk=0, phase=0. Hold reset 2 cycles, release with no requests, run 50 cycles → state stays NSG.
- Gap-out: release reset, req_ew=1 held, req_ns=0 → phase sequence 0×4, 1×3, 2×2, then 3. EW stays green while no NS demand.
- Max-out: req_ns=req_ew=1 held from reset → period-30 sequence: NSG 10, NSY 3, AR1 2, EWG 10, EWY 3, AR2 2. Check the sequence repeats twice.
- Pedestrian: 1-cycle ped_req at cycle 1 of NSG, no car requests → NSG exits after 4 cycles, then NSY 3, AR1 2, WALK 5 with walk=1 and both heads red, then EWG. A ped_req during WALK does not produce a second WALK.
- Latched short demand: 1-cycle req_ew pulse while NSG with req_ns=1 → NSG max-outs at 10 cycles and the sequence reaches EWG. pend_ew clears on EWG entry.
- Safety check over a 2000-cycle random req/ped stimulus:
  - never ns_g&ew_g;
  - exactly one lamp lit per head;
  - walk=1 only when ns_r=ew_r=1;
  - phase never reads 7.
